// File: rtl/truth_sweep_ctrl.sv
// Sweeps all 2^N_IN input vectors into a combinational unit and checks the responses against EXPECTED.
// Latency: 2^N_IN*(SETTLE+2)+1 cycles from accepted start to done; start is sampled only while idle.
// Optional zero-response counter is built when TRUTH_SWEEP_ZERO_CNT_EN is defined.
module truth_sweep_ctrl #(
   parameter int N_IN   = 3,
   parameter int N_OUT  = 2,
   parameter int SETTLE = 2,
   parameter logic [N_OUT*(2**N_IN)-1:0] EXPECTED = 16'hE994
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [N_IN-1:0]   dut_in,
   input  logic [N_OUT-1:0]  dut_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [N_IN:0]     err_count,
   output logic              fail_seen,
   output logic [N_IN-1:0]   first_fail
`ifdef TRUTH_SWEEP_ZERO_CNT_EN
   ,
   output logic [N_IN:0]     zero_count
`endif
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
   localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_WAIT,
      S_SAMPLE,
      S_FINISH
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [N_IN-1:0] idx_q;
   logic [CW-1:0]   cnt_q;
   logic            mismatch;

   assign mismatch = (dut_out != EXPECTED[idx_q*N_OUT +: N_OUT]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start) state_d = S_DRIVE;
         S_DRIVE:  state_d = (SETTLE == 0) ? S_SAMPLE : S_WAIT;
         S_WAIT:   if (cnt_q == CW'(1)) state_d = S_SAMPLE;
         S_SAMPLE: state_d = (idx_q == IDX_LAST) ? S_FINISH : S_DRIVE;
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Results are registered and hold in IDLE until the next accepted start.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q      <= '0;
         cnt_q      <= '0;
         dut_in     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_seen  <= 1'b0;
         first_fail <= '0;
`ifdef TRUTH_SWEEP_ZERO_CNT_EN
         zero_count <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  idx_q      <= '0;
                  err_count  <= '0;
                  fail_seen  <= 1'b0;
                  first_fail <= '0;
                  pass       <= 1'b0;
                  busy       <= 1'b1;
`ifdef TRUTH_SWEEP_ZERO_CNT_EN
                  zero_count <= '0;
`endif
               end
            end
            S_DRIVE: begin
               dut_in <= idx_q;
               cnt_q  <= CW'(SETTLE);
            end
            S_WAIT: begin
               cnt_q <= cnt_q - 1'b1;
            end
            S_SAMPLE: begin
               if (mismatch) begin
                  err_count <= err_count + 1'b1;
                  if (!fail_seen) begin
                     first_fail <= idx_q;
                     fail_seen  <= 1'b1;
                  end
               end
`ifdef TRUTH_SWEEP_ZERO_CNT_EN
               if (dut_out == '0) zero_count <= zero_count + 1'b1;
`endif
               if (idx_q != IDX_LAST) idx_q <= idx_q + 1'b1;
            end
            S_FINISH: begin
               done   <= 1'b1;
               busy   <= 1'b0;
               pass   <= (err_count == '0);
               dut_in <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_truth_sweep_ctrl.sv
// Directed bench for truth_sweep_ctrl: full-adder model on the default instance, SETTLE=0 on a second.
module tb_truth_sweep_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       start0;
   logic [1:0] mode;

   logic [2:0] dut_in,  dut_in0;
   logic [1:0] dut_out, dut_out0;
   logic       busy, done, pass, fail_seen;
   logic       busy0, done0, pass0, fail_seen0;
   logic [3:0] err_count, err_count0;
   logic [2:0] first_fail, first_fail0;
`ifdef TRUTH_SWEEP_ZERO_CNT_EN
   logic [3:0] zero_count, zero_count0;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   truth_sweep_ctrl u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dut_in     (dut_in),
      .dut_out    (dut_out),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .err_count  (err_count),
      .fail_seen  (fail_seen),
      .first_fail (first_fail)
`ifdef TRUTH_SWEEP_ZERO_CNT_EN
      ,
      .zero_count (zero_count)
`endif
   );

   truth_sweep_ctrl #(.SETTLE(0)) u_dut0 (
      .clk        (clk),
      .rst        (rst),
      .start      (start0),
      .dut_in     (dut_in0),
      .dut_out    (dut_out0),
      .busy       (busy0),
      .done       (done0),
      .pass       (pass0),
      .err_count  (err_count0),
      .fail_seen  (fail_seen0),
      .first_fail (first_fail0)
`ifdef TRUTH_SWEEP_ZERO_CNT_EN
      ,
      .zero_count (zero_count0)
`endif
   );

   // Full adder written from its Boolean definition: {carry, sum}.
   function automatic logic [1:0] fa(input logic [2:0] v);
      return {(v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]), ^v};
   endfunction

   // mode 0: good unit, 1: both outputs inverted at vector 5, 2: outputs stuck at 00
   always_comb begin
      dut_out = fa(dut_in);
      if (mode == 2'd2) dut_out = 2'b00;
      else if (mode == 2'd1 && dut_in == 3'd5) dut_out = ~fa(dut_in);
   end
   assign dut_out0 = fa(dut_in0);

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for edge E0, then watch 40 edges; done expected at E0+33.
   task automatic run_main(input logic chk_in, output int done_at, output int n_done);
      done_at = -1;
      n_done  = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_e0", int'(busy), 1);
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (chk_in && k <= 29 && (k % 4) == 1) chk("dut_in_step", int'(dut_in), (k - 1) / 4);
         if (done) begin
            n_done++;
            if (done_at < 0) done_at = k;
         end
      end
      chk("dut_in_idle", int'(dut_in), 0);
      chk("busy_idle", int'(busy), 0);
   endtask

   initial begin
      int d_at, n_d, k_hit, d1, d2, n_low;

      rst    = 1'b1;
      start  = 1'b0;
      start0 = 1'b0;
      mode   = 2'd0;
      tick();
      tick();
      chk("reset_outputs", int'({busy, done, pass, fail_seen, err_count, first_fail, dut_in}), 0);
      rst = 1'b0;
      tick();

      // Good unit, pulsed start.
      run_main(1'b1, d_at, n_d);
      chk("good_done_at", d_at, 33);
      chk("good_done_cnt", n_d, 1);
      chk("good_pass", int'(pass), 1);
      chk("good_err", int'(err_count), 0);
      chk("good_fail_seen", int'(fail_seen), 0);
`ifdef TRUTH_SWEEP_ZERO_CNT_EN
      chk("good_zero_cnt", int'(zero_count), 1);
`endif

      // Single fault at vector 5.
      mode = 2'd1;
      run_main(1'b0, d_at, n_d);
      chk("v5_done_at", d_at, 33);
      chk("v5_err", int'(err_count), 1);
      chk("v5_first_fail", int'(first_fail), 5);
      chk("v5_fail_seen", int'(fail_seen), 1);
      chk("v5_pass", int'(pass), 0);

      // Outputs stuck at 00: only vector 0 matches.
      mode = 2'd2;
      run_main(1'b0, d_at, n_d);
      chk("stuck_err", int'(err_count), 7);
      chk("stuck_first_fail", int'(first_fail), 1);
      chk("stuck_pass", int'(pass), 0);
`ifdef TRUTH_SWEEP_ZERO_CNT_EN
      chk("stuck_zero_cnt", int'(zero_count), 8);
`endif

      // Mid-sweep start is ignored, then reset aborts without done.
      mode  = 2'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      k_hit = -1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (dut_in == 3'd3) begin
            k_hit = k;
            break;
         end
      end
      chk("abort_reach_v3", k_hit, 13);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("abort_ignore_start_in", int'(dut_in), 3);
      chk("abort_ignore_start_busy", int'(busy), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_reset_outputs", int'({busy, done, pass, fail_seen, err_count, first_fail, dut_in}), 0);
      n_d = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (done || busy) n_d++;
      end
      chk("abort_no_done", n_d, 0);
      run_main(1'b0, d_at, n_d);
      chk("after_abort_done_at", d_at, 33);
      chk("after_abort_pass", int'(pass), 1);

      // SETTLE=0 instance: two cycles per vector.
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      d_at = -1;
      for (int k = 1; k <= 30; k++) begin
         tick();
         if (done0 && d_at < 0) d_at = k;
      end
      chk("s0_done_at", d_at, 17);
      chk("s0_pass", int'(pass0), 1);
      chk("s0_err", int'(err_count0), 0);
      chk("s0_fail_seen", int'(fail_seen0), 0);

      // Start held high for 80 cycles: back-to-back sweeps.
      start = 1'b1;
      tick();
      d1 = -1;
      d2 = -1;
      n_d = 0;
      n_low = 0;
      for (int k = 1; k <= 80; k++) begin
         tick();
         if (done) begin
            n_d++;
            if (d1 < 0) d1 = k;
            else if (d2 < 0) d2 = k;
         end
         if (k <= 66 && !busy) n_low++;
      end
      start = 1'b0;
      chk("held_done1", d1, 33);
      chk("held_done2", d2, 67);
      chk("held_done_cnt", n_d, 2);
      chk("held_busy_low", n_low, 1);
      for (int k = 0; k < 60; k++) begin
         tick();
         if (!busy) break;
      end
      chk("held_drain", int'(busy), 0);
      chk("held_pass", int'(pass), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
